memref_rd_streamer: RTL and testbench

Initiator side of the memref read-port protocol. It issues sequential reads to a memory with a fixed read latency and returns the data as a valid/ready stream with backpressure. It drains accelerator result memories, such as maskImg, into downstream checkers, DMA or compare logic. It also feeds memories into stream-consuming kernels.

---
 rtl/memref_rd_streamer_pkg.sv | 27 ++
 rtl/memref_rd_streamer_if.sv | 37 +++
 rtl/memref_rd_streamer_fifo.sv | 66 ++++++
 rtl/memref_rd_streamer.sv | 151 +++++++++++++++
 tb/tb_memref_rd_streamer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memref_rd_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memref_stream_pkg
//  Description : Shared types for the memref read streamer: FSM state
//                encoding, return-path tag and credit-counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package memref_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   // Width of a counter able to hold 0..depth inclusive
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/memref_rd_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : memref_rd_streamer_if
//  Description : Control, memory read port and output stream of the memref
//                read streamer. master = streamer side, slave = environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface memref_rd_streamer_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 10
);
   logic              t;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] mem_p0_addr_data;
   logic              mem_p0_rd_en;
   logic [WIDTH-1:0]  mem_p0_rd_data;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic              out_last;
   logic              out_ready;
   logic              busy;
   logic              done;

   modport master (
      input  t, base, count, mem_p0_rd_data, out_ready,
      output mem_p0_addr_data, mem_p0_rd_en, out_valid, out_data, out_last,
             busy, done
   );

   modport slave (
      output t, base, count, mem_p0_rd_data, out_ready,
      input  mem_p0_addr_data, mem_p0_rd_en, out_valid, out_data, out_last,
             busy, done
   );
endinterface
`default_nettype wire

// File: rtl/memref_rd_streamer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo
//  Description : Synchronous FIFO with registered storage and occupancy
//                count. Simultaneous push and pop is accepted even when full.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_fifo
   import memref_stream_pkg::*;
#(
   parameter int DATA_W = 33,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          din,
   input  logic                       pop,
   output logic [DATA_W-1:0]          dout,
   output logic                       full,
   output logic                       empty,
   output logic [credit_w(DEPTH)-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = credit_w(DEPTH);

   logic [DATA_W-1:0] store [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  occ;
   logic              do_push;
   logic              do_pop;

   assign full    = (occ == CNT_W'(DEPTH));
   assign empty   = (occ == '0);
   assign count   = occ;
   assign dout    = store[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap at DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage write; contents need no reset since occupancy gates the reads
   always_ff @(posedge clk) begin
      if (do_push)
         store[wr_ptr] <= din;
   end
endmodule
`default_nettype wire

// File: rtl/memref_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : memref_rd_streamer
//  Description : Issues sequential reads to a fixed-latency memory and returns
//                the words as a valid/ready stream. Reads are only issued
//                while buffer credit exists, so the FIFO never overflows.
//  Revision    : 1.0  initial release
// ============================================================================
module memref_rd_streamer
   import memref_stream_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int SIZE       = 1024,
   parameter int ADDR_W     = $clog2(SIZE),
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   memref_rd_streamer_if.master bus
);
   localparam int CW = credit_w(FIFO_DEPTH);

   if (RD_LATENCY < 1) begin : g_latency_check
      $error("memref_rd_streamer: RD_LATENCY must be at least 1");
   end
   if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_depth_check
      $error("memref_rd_streamer: FIFO_DEPTH must be >= RD_LATENCY+1");
   end

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W:0]   remaining;
   tag_t              sr [RD_LATENCY];
   logic              rd_en;
   logic              credit_ok;
   logic [CW-1:0]     in_flight;
   logic              done_r;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [WIDTH:0]    fifo_head;
   logic [CW-1:0]     fifo_cnt;
   logic              last_pop;

   assign addr_inc  = (cur_addr == ADDR_W'(SIZE - 1)) ? '0 : cur_addr + 1'b1;
   assign fifo_push = sr[RD_LATENCY-1].valid;
   assign fifo_pop  = !fifo_empty && bus.out_ready;
   assign last_pop  = fifo_pop && fifo_head[WIDTH];

   // Count reads still travelling through the memory latency pipe
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         in_flight = in_flight + CW'(sr[i].valid);
   end

   // Every in-flight read already owns a FIFO slot, so issue only if one is left
   assign credit_ok = !fifo_full &&
                      (({1'b0, in_flight} + {1'b0, fifo_cnt}) < (CW + 1)'(FIFO_DEPTH));

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state and read-enable decode
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.t && (bus.count != '0))
               state_nxt = ISSUE;
         end
         ISSUE: begin
            if (credit_ok) begin
               rd_en = 1'b1;
               if (remaining == (ADDR_W + 1)'(1))
                  state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (last_pop)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address/remaining counters and the registered completion pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr  <= '0;
         remaining <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r <= ((state == IDLE) && bus.t && (bus.count == '0)) ||
                   ((state == DRAIN) && last_pop);
         if ((state == IDLE) && bus.t) begin
            cur_addr  <= bus.base;
            remaining <= bus.count;
         end else if (rd_en) begin
            cur_addr  <= addr_inc;
            remaining <= remaining - 1'b1;
         end
      end
   end

   // Tag pipe matching the memory read latency; reset drops in-flight reads
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++)
            sr[i] <= '0;
      end else begin
         sr[0].valid <= rd_en;
         sr[0].last  <= rd_en && (remaining == (ADDR_W + 1)'(1));
         for (int i = 1; i < RD_LATENCY; i++)
            sr[i] <= sr[i-1];
      end
   end

   stream_fifo #(
      .DATA_W (WIDTH + 1),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   ({sr[RD_LATENCY-1].last, bus.mem_p0_rd_data}),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   assign bus.mem_p0_rd_en     = rd_en;
   assign bus.mem_p0_addr_data = rd_en ? cur_addr : '0;
   assign bus.out_valid        = !fifo_empty;
   assign bus.out_data         = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
   assign bus.out_last         = !fifo_empty && fifo_head[WIDTH];
   assign bus.busy             = (state != IDLE);
   assign bus.done             = done_r;
endmodule
`default_nettype wire

// File: tb/tb_memref_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memref_rd_streamer
//  Description : Directed self-checking bench for memref_rd_streamer with a
//                registered-read memory model (mem[i] = i + 100).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memref_rd_streamer;
   localparam int WIDTH      = 32;
   localparam int SIZE       = 1024;
   localparam int ADDR_W     = 10;
   localparam int RD_LATENCY = 1;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   memref_rd_streamer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   memref_rd_streamer #(
      .WIDTH      (WIDTH),
      .SIZE       (SIZE),
      .ADDR_W     (ADDR_W),
      .RD_LATENCY (RD_LATENCY),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [WIDTH-1:0] mem [SIZE];

   // Registered-read memory model
   always @(posedge clk) begin
      if (bus.mem_p0_rd_en)
         bus.mem_p0_rd_data <= mem[bus.mem_p0_addr_data];
   end

   // Monitor logs, sampled mid-cycle
   int               cyc = 0;
   logic [ADDR_W-1:0] iss_q [$];
   int               iss_cyc_q [$];
   logic [WIDTH-1:0] dat_q [$];
   logic             lst_q [$];
   int               out_cyc_q [$];
   int               done_cnt = 0, done_cyc = 0, busy_seen = 0, valid_seen = 0, stall_viol = 0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   logic             prev_last = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.mem_p0_rd_en) begin
            iss_q.push_back(bus.mem_p0_addr_data);
            iss_cyc_q.push_back(cyc);
         end
         if (bus.out_valid) valid_seen++;
         if (bus.out_valid && bus.out_ready) begin
            dat_q.push_back(bus.out_data);
            lst_q.push_back(bus.out_last);
            out_cyc_q.push_back(cyc);
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.busy) busy_seen++;
         if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                            bus.out_last !== prev_last))
            stall_viol++;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
      end
   end

   task automatic clear_logs();
      iss_q.delete(); iss_cyc_q.delete(); dat_q.delete(); lst_q.delete(); out_cyc_q.delete();
      done_cnt = 0; busy_seen = 0; valid_seen = 0; stall_viol = 0;
   endtask

   // Pulse t for one cycle; returns #1 after the edge that samples it
   task automatic start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
      @(posedge clk); #1;
      bus.t = 1'b1; bus.base = b; bus.count = c;
      @(posedge clk); #1;
      bus.t = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && done_cnt == 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.t = 1'b0; bus.base = '0; bus.count = '0; bus.out_ready = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      checks++;
      if ({bus.mem_p0_rd_en, bus.mem_p0_addr_data, bus.out_valid, bus.out_data,
           bus.out_last, bus.busy, bus.done} !== '0) begin
         errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
      end
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      checks++;
      if ({bus.mem_p0_rd_en, bus.out_valid, bus.busy, bus.done} !== 4'b0) begin
         errors++; $display("FAIL idle_after_reset: got %b required 0000",
                            {bus.mem_p0_rd_en, bus.out_valid, bus.busy, bus.done});
      end
   endtask

   task automatic test_basic();
      int n;
      clear_logs();
      bus.out_ready = 1'b1;
      start(10'd0, 11'd4);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL busy_after_t: got %b required 1", bus.busy);
      end
      n = 0;
      while (n < 20 && bus.out_valid !== 1'b1) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != RD_LATENCY + 1) begin
         errors++; $display("FAIL first_valid_latency: got %0d required %0d", n, RD_LATENCY + 1);
      end
      wait_done(50);
      checks++;
      if (iss_q.size() != 4 || dat_q.size() != 4) begin
         errors++; $display("FAIL basic_sizes: got %0d/%0d required 4/4", iss_q.size(), dat_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= iss_q.size() || iss_q[i] !== ADDR_W'(i) || dat_q[i] !== WIDTH'(i + 100) ||
             lst_q[i] !== (i == 3)) begin
            errors++; $display("FAIL basic_word%0d: got addr %0d data %0d last %b required %0d %0d %b",
                               i, iss_q[i], dat_q[i], lst_q[i], i, i + 100, (i == 3));
         end
      end
      checks++;
      if (iss_cyc_q.size() != 4 || iss_cyc_q[3] - iss_cyc_q[0] != 3 ||
          out_cyc_q.size() != 4 || out_cyc_q[3] - out_cyc_q[0] != 3) begin
         errors++; $display("FAIL basic_back_to_back: issue/output cycles not consecutive");
      end
      checks++;
      if (done_cnt != 1 || out_cyc_q.size() != 4 || done_cyc != out_cyc_q[3] + 1) begin
         errors++; $display("FAIL basic_done: got %0d pulses at cycle %0d required 1 the cycle after last",
                            done_cnt, done_cyc);
      end
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0] ea [4];
      logic [WIDTH-1:0]  ed [4];
      ea = '{10'd1022, 10'd1023, 10'd0, 10'd1};
      ed = '{32'd1122, 32'd1123, 32'd100, 32'd101};
      clear_logs();
      bus.out_ready = 1'b1;
      start(10'd1022, 11'd4);
      wait_done(50);
      checks++;
      if (iss_q.size() != 4 || dat_q.size() != 4 || done_cnt != 1) begin
         errors++; $display("FAIL wrap_sizes: got %0d/%0d done %0d required 4/4 done 1",
                            iss_q.size(), dat_q.size(), done_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= dat_q.size() || iss_q[i] !== ea[i] || dat_q[i] !== ed[i] || lst_q[i] !== (i == 3)) begin
            errors++; $display("FAIL wrap_word%0d: got addr %0d data %0d required %0d %0d",
                               i, iss_q[i], dat_q[i], ea[i], ed[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      clear_logs();
      bus.out_ready = 1'b0;
      start(10'd0, 11'd16);
      repeat (10) @(posedge clk); #1;
      checks++;
      if (iss_q.size() != FIFO_DEPTH || dat_q.size() != 0) begin
         errors++; $display("FAIL stall_reads: got %0d reads required %0d", iss_q.size(), FIFO_DEPTH);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd100) begin
         errors++; $display("FAIL stall_head: got valid %b data %0d required 1 100", bus.out_valid, bus.out_data);
      end
      for (int k = 0; k < 200 && done_cnt == 0; k++) begin
         bus.out_ready = ~bus.out_ready;
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      checks++;
      if (iss_q.size() != 16 || dat_q.size() != 16 || done_cnt != 1) begin
         errors++; $display("FAIL bp_sizes: got reads %0d words %0d done %0d required 16 16 1",
                            iss_q.size(), dat_q.size(), done_cnt);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (i >= dat_q.size() || dat_q[i] !== WIDTH'(i + 100) || lst_q[i] !== (i == 15)) begin
            errors++; $display("FAIL bp_word%0d: got data %0d last %b required %0d %b",
                               i, dat_q[i], lst_q[i], i + 100, (i == 15));
         end
      end
      checks++;
      if (stall_viol != 0) begin
         errors++; $display("FAIL bp_stable: got %0d changes while stalled required 0", stall_viol);
      end
   endtask

   task automatic test_zero_count();
      clear_logs();
      start(10'd7, 11'd0);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL zero_done: got done %b busy %b required 1 0", bus.done, bus.busy);
      end
      repeat (5) @(posedge clk); #1;
      checks++;
      if (iss_q.size() != 0 || done_cnt != 1 || busy_seen != 0) begin
         errors++; $display("FAIL zero_quiet: got reads %0d done %0d busy %0d required 0 1 0",
                            iss_q.size(), done_cnt, busy_seen);
      end
   endtask

   task automatic test_retrigger();
      clear_logs();
      bus.out_ready = 1'b1;
      start(10'd0, 11'd8);
      repeat (2) @(posedge clk); #1;
      bus.t = 1'b1; bus.base = 10'd100; bus.count = 11'd3;
      @(posedge clk); #1;
      bus.t = 1'b0;
      wait_done(60);
      checks++;
      if (iss_q.size() != 8 || done_cnt != 1 || dat_q.size() != 8) begin
         errors++; $display("FAIL retrigger: got reads %0d words %0d done %0d required 8 8 1",
                            iss_q.size(), dat_q.size(), done_cnt);
      end
      checks++;
      if (dat_q.size() != 8 || iss_q[7] !== 10'd7 || dat_q[7] !== 32'd107 || lst_q[7] !== 1'b1) begin
         errors++; $display("FAIL retrigger_tail: got addr %0d data %0d required 7 107", iss_q[7], dat_q[7]);
      end
   endtask

   task automatic test_reset_midflight();
      clear_logs();
      bus.out_ready = 1'b1;
      start(10'd0, 11'd8);
      for (int k = 0; k < 20 && iss_q.size() < 3; k++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({bus.mem_p0_rd_en, bus.mem_p0_addr_data, bus.out_valid, bus.out_data,
           bus.out_last, bus.busy, bus.done} !== '0) begin
         errors++; $display("FAIL midreset_outputs: got nonzero outputs, required all 0");
      end
      clear_logs();
      repeat (10) @(posedge clk); #1;
      checks++;
      if (valid_seen != 0 || iss_q.size() != 0) begin
         errors++; $display("FAIL midreset_stale: got valid %0d reads %0d required 0 0", valid_seen, iss_q.size());
      end
      start(10'd5, 11'd2);
      wait_done(50);
      checks++;
      if (dat_q.size() != 2 || dat_q[0] !== 32'd105 || dat_q[1] !== 32'd106 ||
          lst_q[1] !== 1'b1 || done_cnt != 1) begin
         errors++; $display("FAIL midreset_restart: got %0d words first %0d required 2 words 105 106",
                            dat_q.size(), dat_q[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'(i + 100);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_count();
      test_retrigger();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
